l2_mem_arbiter: RTL and testbench

//  Shares one single-port 64-bit L2 SRAM between NB_PORTS requesters (req/gnt/r_valid style).

---
 rtl/l2_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_l2_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter sharing one single-port 64-bit L2 SRAM bank,
// with a sequential clear engine that zeroes the bank after reset or on request.
module l2_mem_arbiter #(
  parameter int NB_PORTS       = 4,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  output logic                               busy_o,
  input  logic [NB_PORTS-1:0]                req_i,
  input  logic [NB_PORTS-1:0]                wen_i,
  input  logic [NB_PORTS*MEM_ADDR_WIDTH-1:0] add_i,
  input  logic [NB_PORTS*8-1:0]              be_i,
  input  logic [NB_PORTS*64-1:0]             wdata_i,
  output logic [NB_PORTS-1:0]                gnt_o,
  output logic [NB_PORTS-1:0]                r_valid_o,
  output logic [63:0]                        r_rdata_o,
  output logic                               mem_csn_o,
  output logic                               mem_wen_o,
  output logic [7:0]                         mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0]          mem_add_o,
  output logic [63:0]                        mem_wdata_o,
  input  logic [63:0]                        mem_rdata_i
);

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int PW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
  localparam logic [AW-1:0] CLR_LAST = '1;

  typedef enum logic {ST_CLEAR, ST_ARB} state_e;

  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;

  state_e                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [NB_PORTS-1:0]   r_valid_q, r_valid_d;

  logic                  win_found;
  logic [PW-1:0]         win_idx;
  logic                  grant_en;
  int                    sel_idx;

  // Search order starts at rr_ptr and wraps modulo NB_PORTS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sel_idx   = 0;
    for (int i = 0; i < NB_PORTS; i++) begin
      sel_idx = int'(rr_ptr_q) + i;
      if (sel_idx >= NB_PORTS) sel_idx = sel_idx - NB_PORTS;
      if (!win_found && req_i[sel_idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(sel_idx);
      end
    end
  end

  assign grant_en = !rst_i && (state_q == ST_ARB) && win_found;
  assign gnt_o    = grant_en ? (NB_PORTS'(1) << win_idx) : '0;
  assign busy_o   = (state_q == ST_CLEAR);

  always_comb begin
    mem_csn_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_be_o    = '0;
    mem_add_o   = '0;
    mem_wdata_o = '0;
    if (rst_i) begin
      mem_csn_o = 1'b1;
    end else if (state_q == ST_CLEAR) begin
      mem_csn_o = 1'b0;
      mem_wen_o = 1'b0;
      mem_be_o  = 8'hFF;
      mem_add_o = clr_cnt_q;
    end else if (win_found) begin
      mem_csn_o   = 1'b0;
      mem_wen_o   = wen_i[win_idx];
      mem_be_o    = be_i[win_idx*8 +: 8];
      mem_add_o   = add_i[win_idx*AW +: AW];
      mem_wdata_o = wdata_i[win_idx*64 +: 64];
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    clr_cnt_d = clr_cnt_q;
    r_valid_d = gnt_o;
    unique case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (grant_en) begin
          if (int'(win_idx) == NB_PORTS - 1) rr_ptr_d = '0;
          else rr_ptr_d = win_idx + 1'b1;
        end
        if (clear_i) state_d = ST_CLEAR;
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RST_STATE;
      rr_ptr_q  <= '0;
      clr_cnt_q <= '0;
      r_valid_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      clr_cnt_q <= clr_cnt_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench for l2_mem_arbiter (4 ports, 16-word bank)
// with a behavioural single-port SRAM attached.
module tb_l2_mem_arbiter;

  localparam int NP = 4;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          busy;
  logic [NP-1:0] req;
  logic [NP-1:0] wen;
  logic [NP*AW-1:0] add;
  logic [NP*8-1:0]  be;
  logic [NP*64-1:0] wdata;
  logic [NP-1:0] gnt;
  logic [NP-1:0] rvalid;
  logic [63:0]   rdata;
  logic          mem_csn;
  logic          mem_wen;
  logic [7:0]    mem_be;
  logic [AW-1:0] mem_add;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;

  logic [63:0]   sram [16];

  int n_chk  = 0;
  int n_pass = 0;

  l2_mem_arbiter #(
    .NB_PORTS(NP),
    .MEM_ADDR_WIDTH(AW),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .clear_i(clear),
    .busy_o(busy),
    .req_i(req),
    .wen_i(wen),
    .add_i(add),
    .be_i(be),
    .wdata_i(wdata),
    .gnt_o(gnt),
    .r_valid_o(rvalid),
    .r_rdata_o(rdata),
    .mem_csn_o(mem_csn),
    .mem_wen_o(mem_wen),
    .mem_be_o(mem_be),
    .mem_add_o(mem_add),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk) begin
    if (!mem_csn) begin
      if (!mem_wen) begin
        for (int b = 0; b < 8; b++)
          if (mem_be[b]) sram[mem_add][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_add];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout n_pass=%0d n_chk=%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [7:0] b, input logic [63:0] d);
    req[p]          = 1'b1;
    wen[p]          = w;
    add[p*AW +: AW] = a;
    be[p*8 +: 8]    = b;
    wdata[p*64 +: 64] = d;
  endtask

  task automatic idle();
    req = '0;
  endtask

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    req   = '0;
    wen   = '1;
    add   = '0;
    be    = '0;
    wdata = '0;
    mem_rdata = '0;

    // T1: reset values, then 16 clear writes while port 2 waits
    repeat (2) @(negedge clk);
    set_port(2, 1'b1, 4'd0, 8'hFF, 64'd0);
    #1;
    chk("rst_csn", 64'(mem_csn), 64'd1);
    chk("rst_wen", 64'(mem_wen), 64'd1);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("clr_add", 64'(mem_add), 64'(k));
      chk("clr_ctl", 64'({mem_csn, mem_wen, mem_be}), 64'h0FF);
      chk("clr_wdata", mem_wdata, 64'd0);
      chk("clr_busy_gnt", 64'({busy, gnt}), 64'h10);
      @(negedge clk);
    end
    #1;
    chk("t1_busy_done", 64'(busy), 64'd0);
    chk("t1_gnt2", 64'(gnt), 64'h4);
    @(negedge clk);
    idle();
    #1;
    chk("t1_rvalid2", 64'(rvalid), 64'h4);
    chk("t1_rdata0", rdata, 64'd0);

    // T2: port 1 write then read addr 3
    set_port(1, 1'b0, 4'd3, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    #1;
    chk("t2_gnt_wr", 64'(gnt), 64'h2);
    chk("t2_mem_wen", 64'(mem_wen), 64'd0);
    @(negedge clk);
    set_port(1, 1'b1, 4'd3, 8'hFF, 64'd0);
    #1;
    chk("t2_rvalid_wr", 64'(rvalid), 64'h2);
    chk("t2_gnt_rd", 64'(gnt), 64'h2);
    @(negedge clk);
    idle();
    #1;
    chk("t2_rvalid_rd", 64'(rvalid), 64'h2);
    chk("t2_rdata", rdata, 64'hDEADBEEF_CAFEF00D);

    // T3: partial byte-enable write on addr 5
    set_port(0, 1'b0, 4'd5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    #1 chk("t3_gnt_a", 64'(gnt), 64'h1);
    @(negedge clk);
    set_port(0, 1'b0, 4'd5, 8'h0F, 64'd0);
    #1 chk("t3_be", 64'(mem_be), 64'h0F);
    @(negedge clk);
    set_port(0, 1'b1, 4'd5, 8'h00, 64'd0);
    #1 chk("t3_gnt_rd", 64'(gnt), 64'h1);
    @(negedge clk);
    idle();
    #1 chk("t3_rdata", rdata, 64'hFFFFFFFF_00000000);

    // T4: port 3 alone moves rr_ptr back to 0, then all four request
    set_port(3, 1'b1, 4'd0, 8'h00, 64'd0);
    #1 chk("t4_gnt3", 64'(gnt), 64'h8);
    @(negedge clk);
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 4'(p), 8'h00, 64'd0);
    for (int j = 0; j < 6; j++) begin
      #1;
      chk("t4_rr_all", 64'(gnt), 64'(1) << (j % 4));
      if (j > 0) chk("t4_rvalid", 64'(rvalid), 64'(1) << ((j - 1) % 4));
      @(negedge clk);
    end
    req = 4'b1010;
    #1 chk("t4_rvalid_last", 64'(rvalid), 64'h2);
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("t4_rr_13", 64'(gnt), (j % 2 == 0) ? 64'h8 : 64'h2);
      @(negedge clk);
    end
    idle();

    // T5: clear with a same-cycle read grant; mid-clear pulse ignored
    set_port(0, 1'b1, 4'd3, 8'h00, 64'd0);
    clear = 1'b1;
    #1 chk("t5_gnt0", 64'(gnt), 64'h1);
    @(negedge clk);
    clear = 1'b0;
    idle();
    #1;
    chk("t5_rvalid0", 64'(rvalid), 64'h1);
    chk("t5_rdata", rdata, 64'hDEADBEEF_CAFEF00D);
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("t5_clr_add", 64'(mem_add), 64'(k));
      chk("t5_busy", 64'(busy), 64'd1);
      clear = (k == 5);
      @(negedge clk);
    end
    clear = 1'b0;
    #1 chk("t5_busy_done", 64'(busy), 64'd0);
    set_port(2, 1'b1, 4'd3, 8'h00, 64'd0);
    #1 chk("t5_gnt2", 64'(gnt), 64'h4);
    @(negedge clk);
    idle();
    #1 chk("t5_rd3_zero", rdata, 64'd0);
    set_port(0, 1'b1, 4'd5, 8'h00, 64'd0);
    @(negedge clk);
    idle();
    #1 chk("t5_rd5_zero", rdata, 64'd0);

    // T6: reset mid-clear at address 7
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t6_clr_add", 64'(mem_add), 64'(k));
      if (k < 7) @(negedge clk);
    end
    set_port(1, 1'b1, 4'd2, 8'h00, 64'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_ctl", 64'({mem_csn, mem_wen}), 64'h3);
    chk("t6_rst_gnt", 64'(gnt), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1 chk("t6_restart_add", 64'(mem_add), 64'(k));
      @(negedge clk);
    end
    #1;
    chk("t6_busy_done", 64'(busy), 64'd0);
    chk("t6_gnt1", 64'(gnt), 64'h2);
    @(negedge clk);
    idle();
    #1 chk("t6_rvalid1", 64'(rvalid), 64'h2);
    rst = 1'b1;
    #1 chk("t6_rvalid_drop", 64'(rvalid), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
